// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand fetch stage.
// Contents: reg_addr_t (5-bit register index), word_t (XLEN-wide datum),
//           REG_ZERO (hardwired zero register), NUM_REGS (register count).
package cpu_pkg;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/operand_fetch_stage_if.sv
// Handshake bundles around the operand fetch stage.
//   operand_fetch_id_if : decode -> fetch stage (id_valid/id_ready + decoded fields)
//     master = decode side, slave = operand_fetch_stage
//   operand_fetch_ex_if : fetch stage -> execute (ex_valid/ex_ready + operands)
//     master = operand_fetch_stage, slave = execute side
interface operand_fetch_id_if #(parameter int PAYLOAD_W = 32);
    import cpu_pkg::*;
    logic                 id_valid;
    logic                 id_ready;
    reg_addr_t            id_rs1;
    reg_addr_t            id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    reg_addr_t            id_rd;
    logic                 id_rd_we;
    logic [PAYLOAD_W-1:0] id_payload;

    modport master (output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
                           id_rd, id_rd_we, id_payload,
                    input  id_ready);
    modport slave  (input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
                           id_rd, id_rd_we, id_payload,
                    output id_ready);
endinterface

interface operand_fetch_ex_if #(parameter int XLEN = 32, parameter int PAYLOAD_W = 32);
    import cpu_pkg::*;
    logic                 ex_valid;
    logic                 ex_ready;
    logic [XLEN-1:0]      ex_rs1_data;
    logic [XLEN-1:0]      ex_rs2_data;
    reg_addr_t            ex_rd;
    logic                 ex_rd_we;
    logic [PAYLOAD_W-1:0] ex_payload;

    modport master (output ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, ex_payload,
                    input  ex_ready);
    modport slave  (input  ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, ex_payload,
                    output ex_ready);
endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared on writeback (or when a flushed writer is killed).
// Ports: clk/rst; set_en_i/set_addr_i (issue), clr_en_i/clr_addr_i (writeback),
//        fclr_en_i/fclr_addr_i (flush kill); chk1/chk2 read-check ports;
//        pending_o full vector.
module operand_scoreboard
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_addr_i,
    input  logic                fclr_en_i,
    input  reg_addr_t           fclr_addr_i,
    input  reg_addr_t           chk1_addr_i,
    output logic                chk1_pend_o,
    input  reg_addr_t           chk2_addr_i,
    output logic                chk2_pend_o,
    output logic [NUM_REGS-1:0] pending_o
);
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // Clears first, set last: a new writer issuing in the same cycle as the
    // previous writer's writeback must leave the register pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i)  pending_d[clr_addr_i]  = 1'b0;
        if (fclr_en_i) pending_d[fclr_addr_i] = 1'b0;
        if (set_en_i)  pending_d[set_addr_i]  = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign chk1_pend_o = pending_q[chk1_addr_i];
    assign chk2_pend_o = pending_q[chk2_addr_i];
    assign pending_o   = pending_q;
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage: reads the register file, merges writeback
// bypass, stalls RAW/WAW hazards against the pending-write scoreboard and
// registers the result into a valid/ready execute slot (1-cycle latency).
// Ports: clk, reset (async, active high), flush; id (decode handshake, slave);
//        ex (execute slot, master); rf_read_address1/2, rf_read_data1/2;
//        wb_wren/wb_address/wb_data writeback.
// Config: OPERAND_FETCH_BYPASS_EN defined enables the writeback bypass;
//         undefined, a source waiting on a same-cycle writeback stalls one
//         more cycle and reads the register file instead.
module operand_fetch_stage #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    operand_fetch_id_if.slave     id,
    operand_fetch_ex_if.master    ex,
    output cpu_pkg::reg_addr_t    rf_read_address1,
    output cpu_pkg::reg_addr_t    rf_read_address2,
    input  logic [XLEN-1:0]       rf_read_data1,
    input  logic [XLEN-1:0]       rf_read_data2,
    input  logic                  wb_wren,
    input  cpu_pkg::reg_addr_t    wb_address,
    input  logic [XLEN-1:0]       wb_data
);
    import cpu_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic                 ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    reg_addr_t            ex_rd_q, ex_rd_d;
    logic                 ex_rd_we_q, ex_rd_we_d;
    logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;

    logic                 pend1, pend2;
    logic [NUM_REGS-1:0]  pending;
    logic                 wb_live, byp1, byp2, byp_rd;
    logic                 haz1, haz2, waw, issue;
    logic [XLEN-1:0]      op1, op2;

    assign rf_read_address1 = id.id_rs1;
    assign rf_read_address2 = id.id_rs2;

    // Writebacks to r0 never bypass and never touch the scoreboard.
    assign wb_live = wb_wren & (wb_address != REG_ZERO);
    assign byp1    = BYPASS_EN & wb_live & (wb_address == id.id_rs1);
    assign byp2    = BYPASS_EN & wb_live & (wb_address == id.id_rs2);
    assign byp_rd  = BYPASS_EN & wb_live & (wb_address == id.id_rd);

    assign haz1 = id.id_use_rs1 & (id.id_rs1 != REG_ZERO) & pend1 & ~byp1;
    assign haz2 = id.id_use_rs2 & (id.id_rs2 != REG_ZERO) & pend2 & ~byp2;
    assign waw  = id.id_rd_we & (id.id_rd != REG_ZERO) & pending[id.id_rd] & ~byp_rd;

    assign id.id_ready = (~ex_valid_q | ex.ex_ready) & ~haz1 & ~haz2 & ~waw & ~flush;
    assign issue       = id.id_valid & id.id_ready;

    assign op1 = (id.id_rs1 == REG_ZERO) ? '0 : (byp1 ? wb_data : rf_read_data1);
    assign op2 = (id.id_rs2 == REG_ZERO) ? '0 : (byp2 ? wb_data : rf_read_data2);

    // Killing a writer in the slot releases its destination; writers already
    // handed to execute stay pending until their own writeback.
    operand_scoreboard u_sb (
        .clk         (clk),
        .rst         (reset),
        .set_en_i    (issue & id.id_rd_we & (id.id_rd != REG_ZERO)),
        .set_addr_i  (id.id_rd),
        .clr_en_i    (wb_live),
        .clr_addr_i  (wb_address),
        .fclr_en_i   (flush & ex_valid_q & ex_rd_we_q),
        .fclr_addr_i (ex_rd_q),
        .chk1_addr_i (id.id_rs1),
        .chk1_pend_o (pend1),
        .chk2_addr_i (id.id_rs2),
        .chk2_pend_o (pend2),
        .pending_o   (pending)
    );

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_rd_we_d   = ex_rd_we_q;
        ex_payload_d = ex_payload_q;
        if (issue) begin
            ex_valid_d   = 1'b1;
            ex_rs1_d     = op1;
            ex_rs2_d     = op2;
            ex_rd_d      = id.id_rd;
            ex_rd_we_d   = id.id_rd_we;
            ex_payload_d = id.id_payload;
        end else if (flush | ex.ex_ready) begin
            ex_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= REG_ZERO;
            ex_rd_we_q   <= 1'b0;
            ex_payload_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_we_q   <= ex_rd_we_d;
            ex_payload_q <= ex_payload_d;
        end
    end

    assign ex.ex_valid    = ex_valid_q;
    assign ex.ex_rs1_data = ex_rs1_q;
    assign ex.ex_rs2_data = ex_rs2_q;
    assign ex.ex_rd       = ex_rd_q;
    assign ex.ex_rd_we    = ex_rd_we_q;
    assign ex.ex_payload  = ex_payload_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: stimulus pushes expected execute
// slot contents on each accepted issue; a monitor pops and compares whenever
// the slot is consumed (flushed slots are discarded).
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush;
    reg_addr_t   rf_read_address1, rf_read_address2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_wren;
    reg_addr_t   wb_address;
    logic [31:0] wb_data;
    logic [31:0] rf [32];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pl;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    operand_fetch_id_if #(.PAYLOAD_W(32))             idb ();
    operand_fetch_ex_if #(.XLEN(32), .PAYLOAD_W(32))  exb ();

    operand_fetch_stage #(.XLEN(32), .PAYLOAD_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .id               (idb),
        .ex               (exb),
        .rf_read_address1 (rf_read_address1),
        .rf_read_address2 (rf_read_address2),
        .rf_read_data1    (rf_read_data1),
        .rf_read_data2    (rf_read_data2),
        .wb_wren          (wb_wren),
        .wb_address       (wb_address),
        .wb_data          (wb_data)
    );

    // Register file model; r0 reads as all ones so the stage must force zero.
    always @(posedge clk) if (wb_wren) rf[wb_address] <= wb_data;
    assign rf_read_data1 = (rf_read_address1 == 5'd0) ? 32'hFFFF_FFFF : rf[rf_read_address1];
    assign rf_read_data2 = (rf_read_address2 == 5'd0) ? 32'hFFFF_FFFF : rf[rf_read_address2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] rd, input logic we, input logic [31:0] pl);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.rd = rd; e.we = we; e.pl = pl;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic [31:0] pl);
        idb.id_rs1 = rs1; idb.id_use_rs1 = u1;
        idb.id_rs2 = rs2; idb.id_use_rs2 = u2;
        idb.id_rd  = rd;  idb.id_rd_we   = we;
        idb.id_payload = pl;
        idb.id_valid   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, record expectation.
    task automatic issue(input string nm, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic [31:0] pl,
                         input logic [31:0] e1, input logic [31:0] e2, input int exp_stall);
        int n = 0;
        bit ok = 0;
        drive(rs1, u1, rs2, u2, rd, we, pl);
        while (n <= 20) begin
            @(negedge clk);
            if (idb.id_ready) begin ok = 1; break; end
            n++;
            tick();
        end
        if (ok) push(e1, e2, rd, we, pl);
        chk({nm, "_accepted"}, 64'(ok), 64'd1);
        chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        tick();
        idb.id_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_wren = 1'b1; wb_address = a; wb_data = d;
        tick();
        wb_wren = 1'b0;
    endtask

    // Monitor: consumes one expectation per slot handoff or flush kill.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && exb.ex_valid) begin
                if (flush) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                end else if (exb.ex_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ex_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ex_rs1_data", 64'(exb.ex_rs1_data), 64'(e.d1));
                        chk("ex_rs2_data", 64'(exb.ex_rs2_data), 64'(e.d2));
                        chk("ex_rd",       64'(exb.ex_rd),       64'(e.rd));
                        chk("ex_rd_we",    64'(exb.ex_rd_we),    64'(e.we));
                        chk("ex_payload",  64'(exb.ex_payload),  64'(e.pl));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        wb_wren = 1'b0; wb_address = '0; wb_data = '0;
        idb.id_valid = 1'b0; idb.id_rs1 = '0; idb.id_rs2 = '0;
        idb.id_use_rs1 = 1'b0; idb.id_use_rs2 = 1'b0;
        idb.id_rd = '0; idb.id_rd_we = 1'b0; idb.id_payload = '0;
        exb.ex_ready = 1'b1;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_ex_valid",   64'(exb.ex_valid),    64'd0);
        chk("rst_ex_rs1",     64'(exb.ex_rs1_data), 64'd0);
        chk("rst_ex_rs2",     64'(exb.ex_rs2_data), 64'd0);
        chk("rst_ex_rd",      64'(exb.ex_rd),       64'd0);
        chk("rst_ex_payload", 64'(exb.ex_payload),  64'd0);
        chk("rst_pending",    64'(dut.u_sb.pending_q), 64'd0);
        chk("rst_id_ready",   64'(idb.id_ready),    64'd1);
        tick();
        reset = 1'b0;

        wb(5'd5, 32'h11); wb(5'd6, 32'h22); wb(5'd9, 32'h99); wb(5'd3, 32'h33);

        // 1: plain read of two sources
        issue("t1", 5'd5, 1, 5'd6, 1, 5'd0, 0, 32'hA1, 32'h11, 32'h22, 0);

        // 2: RAW on r7 resolved by writeback
        issue("t2w", 5'd0, 0, 5'd0, 0, 5'd7, 1, 32'hA2, 32'h0, 32'h0, 0);
        drive(5'd7, 1, 5'd0, 0, 5'd8, 0, 32'hA3);
        @(negedge clk); chk("t2_stall0", 64'(idb.id_ready), 64'd0); tick();
        @(negedge clk); chk("t2_stall1", 64'(idb.id_ready), 64'd0); tick();
        wb_wren = 1'b1; wb_address = 5'd7; wb_data = 32'hABCD;
        @(negedge clk);
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("t2_bypass_ready", 64'(idb.id_ready), 64'd1);
        push(32'hABCD, 32'h0, 5'd8, 1'b0, 32'hA3);
        tick();
        wb_wren = 1'b0;
`else
        chk("t2_wbcycle_stall", 64'(idb.id_ready), 64'd0);
        tick();
        wb_wren = 1'b0;
        @(negedge clk);
        chk("t2_after_wb_ready", 64'(idb.id_ready), 64'd1);
        push(32'hABCD, 32'h0, 5'd8, 1'b0, 32'hA3);
        tick();
`endif
        idb.id_valid = 1'b0;
        tick();

        // 3: backpressure holds the slot
        exb.ex_ready = 1'b0;
        issue("t3a", 5'd5, 1, 5'd6, 1, 5'd10, 0, 32'hB1, 32'h11, 32'h22, 0);
        drive(5'd6, 1, 5'd5, 1, 5'd11, 0, 32'hB2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_id_ready",  64'(idb.id_ready),    64'd0);
            chk("t3_ex_valid",  64'(exb.ex_valid),    64'd1);
            chk("t3_hold_rs1",  64'(exb.ex_rs1_data), 64'h11);
            chk("t3_hold_pl",   64'(exb.ex_payload),  64'hB1);
            tick();
        end
        exb.ex_ready = 1'b1;
        issue("t3b", 5'd6, 1, 5'd5, 1, 5'd11, 0, 32'hB2, 32'h22, 32'h11, 0);

        // 4: r0 never pending, always reads zero
        issue("t4w", 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'hC1, 32'h0, 32'h0, 0);
        issue("t4r", 5'd0, 1, 5'd5, 1, 5'd12, 0, 32'hC2, 32'h0, 32'h11, 0);
        chk("t4_pending", 64'(dut.u_sb.pending_q), 64'd0);
        tick();

        // 5: flush kills a writer in the slot and releases its destination
        exb.ex_ready = 1'b0;
        issue("t5w", 5'd0, 0, 5'd0, 0, 5'd9, 1, 32'hD1, 32'h0, 32'h0, 0);
        exb.ex_ready = 1'b1;
        flush = 1'b1;
        drive(5'd5, 1, 5'd0, 0, 5'd0, 0, 32'hDF);
        @(negedge clk);
        chk("t5_flush_blocks", 64'(idb.id_ready), 64'd0);
        chk("t5_pend9_before", 64'(dut.u_sb.pending_q[9]), 64'd1);
        tick();
        flush = 1'b0; idb.id_valid = 1'b0;
        @(negedge clk);
        chk("t5_ex_valid", 64'(exb.ex_valid), 64'd0);
        chk("t5_pend9",    64'(dut.u_sb.pending_q[9]), 64'd0);
        tick();
        issue("t5r", 5'd9, 1, 5'd0, 0, 5'd13, 0, 32'hD2, 32'h99, 32'h0, 0);

        // 6: writeback and new writer of r3 coincide -> r3 stays pending
        issue("t6w", 5'd0, 0, 5'd0, 0, 5'd3, 1, 32'hE1, 32'h0, 32'h0, 0);
        drive(5'd0, 0, 5'd0, 0, 5'd3, 1, 32'hE2);
        wb_wren = 1'b1; wb_address = 5'd3; wb_data = 32'h3333;
        @(negedge clk);
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("t6_ready", 64'(idb.id_ready), 64'd1);
`else
        chk("t6_waw_stall", 64'(idb.id_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("t6_ready", 64'(idb.id_ready), 64'd1);
`endif
        push(32'h0, 32'h0, 5'd3, 1'b1, 32'hE2);
        tick();
        idb.id_valid = 1'b0; wb_wren = 1'b0; exb.ex_ready = 1'b0;
        @(negedge clk);
        chk("t6_pend3", 64'(dut.u_sb.pending_q[3]), 64'd1);
        drive(5'd3, 1, 5'd0, 0, 5'd14, 0, 32'hE3);
        exb.ex_ready = 1'b1;
        #1;
        chk("t6_raw_stall", 64'(idb.id_ready), 64'd0);
        exb.ex_ready = 1'b0;
        tick();

        // Mid-stream reset drops slot and scoreboard immediately
        idb.id_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_ex_valid", 64'(exb.ex_valid),        64'd0);
        chk("midrst_pending",  64'(dut.u_sb.pending_q),  64'd0);
        chk("midrst_payload",  64'(exb.ex_payload),      64'd0);
        tick();
        reset = 1'b0; exb.ex_ready = 1'b1;
        tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
